mac_dot_acc: RTL and testbench
==============================

# mac_dot_acc

Parametrised, pipelined multiply-accumulate engine computing one dot product per framed input vector. It replaces the fixed 8×8 unsigned MAC in the perceptron datapath, adding generic operand widths, signed mode, first/last vector framing with a result strobe, and overflow reporting. It sits between the pixel/weight fetch logic and the activation/compare stage.

## Interface
- `A_W`, default 8: width of operand `dataa`.
- `B_W`, default 8: width of operand `datab`.
- `GUARD_W`, default 10: accumulator guard bits; `ACC_W = A_W + B_W + GUARD_W` (default 26, covering 784 full-scale products).
- `SIGNED`, default 0: 0 treats operands as unsigned; 1 treats them as two's complement.
- `clk` in 1: single clock, rising edge.
- `aclr` in 1: reset, asynchronous and active-high; clears every register.
- `clken` in 1: pipeline enable; when low, all pipeline and accumulator registers hold.
- `in_valid` in 1: qualifies `dataa`, `datab`, `in_first` and `in_last`.
- `in_first` in 1: marks the first element of a vector.
- `in_last` in 1: marks the last element of a vector.
- `dataa` in A_W: operand A.
- `datab` in B_W: operand B.
- `dataout` out ACC_W: final dot product of the most recent vector.
- `dout_valid` out 1: one-cycle strobe indicating that `dataout` and `dout_ovf` are new.
- `dout_ovf` out 1: the vector overflowed ACC_W.

## Operation
- Stage 1 registers `dataa`, `datab`, `in_valid`, `in_first` and `in_last`.
- Stage 2 registers the full-precision product (A_W+B_W bits) and the flags.
- Stage 3 (accumulator):
  - if the stage-2 valid bit is set and first is set, `acc` ← the product, sign- or zero-extended to ACC_W, and the sticky overflow flag ← 0;
  - if valid is set and first is clear, `acc` ← `acc` + product, and sticky overflow |= the overflow of this add.
- Overflow detection:
  - unsigned: carry out of ACC_W;
  - signed: both addends have equal sign and the result sign differs.
- When stage-2 valid and last are both set, the stage-3 update also loads `dataout` with the new `acc` value, loads `dout_ovf` with the updated sticky flag, and pulses `dout_valid`.
- `in_first` and `in_last` together: the vector is one element long and `dataout` equals that product.
- `in_first` arriving mid-vector: the partial sum is discarded silently and accumulation restarts.
- Elements arriving after `in_last` without `in_first` continue from the last `acc` value; the block neither rejects nor flags them.
- Beats with `in_valid` low are bubbles: they propagate through the pipeline and leave `acc` unchanged.
- `dataout` and `dout_ovf` hold their values until the next result.

## Timing
- Reset values: `dataout` = 0, `dout_valid` = 0, `dout_ovf` = 0; `acc`, the sticky flag and all pipeline valid bits = 0.
- Latency: when the last element is sampled at rising edge E, `dout_valid` is asserted after edge E+2 and stays high for exactly one cycle.
- Throughput: one element per clock; results are back-to-back capable, so a one-element vector every cycle yields a strobe every cycle.
- While `clken` is low, every register holds and `dout_valid` is forced to 0. Enabled edges, not clock cycles, count toward latency.
- `aclr` asserted mid-vector aborts immediately. No strobe is emitted for the aborted vector, and the first vector after release must carry `in_first`.

## Configuration
- `MAC_SAT_EN` defined: on overflow, `acc` clamps. Unsigned clamps to 2^ACC_W−1. Signed clamps to +2^(ACC_W−1)−1 or −2^(ACC_W−1), according to the addend sign. Once clamped, `acc` stays clamped for the rest of the vector, while `dout_ovf` still reports.
- `MAC_SAT_EN` undefined: `acc` wraps modulo 2^ACC_W and `dout_ovf` reports the wrap.

## Structure
- Package `mac_pkg` holds:
  - an ACC_W helper function;
  - saturation constant functions (max/min per signedness);
  - the typedef for the stage flag bundle `{valid, first, last}`.
- Sub-module `mac_mult_stage` holds stages 1–2 (operand registers plus product register, parametrised by A_W, B_W and SIGNED). `mac_dot_acc` instantiates it and owns the accumulator, overflow logic and output registers.

## Test plan
- Unsigned default widths, vector (3,4),(5,6),(7,8) with first and last flags set → one `dout_valid` strobe 3 edges after the last element, `dataout` = 12+30+56 = 98, `dout_ovf` = 0.
- SIGNED=1, vector (−3,4),(2,−5) → `dataout` = −22 (0x3FFFFEA at ACC_W = 26); then a one-element vector with first and last set, (−128,−128) → `dataout` = 16384 on the very next strobe.
- GUARD_W=0 unsigned, vector (255,255) twice → wrap: `dataout` = 0x1FC02 & 0xFFFF = 0xFC02 with `dout_ovf` = 1 without the macro; with `MAC_SAT_EN`, `dataout` = 0xFFFF and `dout_ovf` = 1.
- Vector (2,2),(2,2) with `clken` low for 5 cycles between the elements, and bubbles (`in_valid` = 0) interleaved → `dataout` = 8, a single strobe, and no strobe while `clken` is low.
- `aclr` pulsed after the second element of a 4-element vector → all outputs = 0 and no strobe; the next vector (1,1) with first and last set → `dataout` = 1.
- `in_first` reasserted mid-vector: (9,9) followed by (1,1) carrying first+last → `dataout` = 1.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared types and constant helpers for the mac_dot_acc datapath: stage flag
// bundle, accumulator width and saturation limits.
package mac_pkg;

  localparam int MAX_ACC_W = 64;

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } stage_flags_t;

  function automatic int acc_width(input int a_w, input int b_w, input int guard_w);
    return a_w + b_w + guard_w;
  endfunction

  // Largest representable accumulator value, right-aligned in MAX_ACC_W bits.
  function automatic logic [MAX_ACC_W-1:0] sat_max(input bit sgn, input int w);
    logic [MAX_ACC_W-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_ACC_W; i++) begin
      if ((i < w - 1) || ((i == w - 1) && !sgn)) r[i] = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [MAX_ACC_W-1:0] sat_min(input bit sgn, input int w);
    logic [MAX_ACC_W-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_ACC_W; i++) begin
      if (sgn && (i == w - 1)) r[i] = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mac_mult_stage.sv
// Operand register + full-precision product register (2 enabled edges, in to prod_q).
// No backpressure: clken stalls both stages; flags travel alongside the data.
module mac_mult_stage
  import mac_pkg::*;
#(
  parameter int A_W    = 8,
  parameter int B_W    = 8,
  parameter int SIGNED = 0
) (
  input  logic                 clk,
  input  logic                 aclr,
  input  logic                 clken,
  input  stage_flags_t         in_flags,
  input  logic [A_W-1:0]       dataa,
  input  logic [B_W-1:0]       datab,
  output logic [A_W+B_W-1:0]   prod_q,
  output stage_flags_t         flags_q
);

  localparam int P_W = A_W + B_W;

  logic [A_W-1:0] a_q, a_d;
  logic [B_W-1:0] b_q, b_d;
  stage_flags_t   s1_q, s1_d;
  stage_flags_t   flags_d;
  logic [P_W-1:0] prod_d;
  logic [P_W-1:0] a_ext, b_ext;

  // Both operands extended to the product width, so the low P_W bits of the
  // product are exact for either signedness.
  always_comb begin
    a_ext = (SIGNED != 0) ? P_W'($signed(a_q)) : P_W'(a_q);
    b_ext = (SIGNED != 0) ? P_W'($signed(b_q)) : P_W'(b_q);
  end

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    s1_d    = s1_q;
    prod_d  = prod_q;
    flags_d = flags_q;
    if (clken) begin
      a_d     = dataa;
      b_d     = datab;
      s1_d    = in_flags;
      prod_d  = a_ext * b_ext;
      flags_d = s1_q;
    end
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      a_q     <= '0;
      b_q     <= '0;
      s1_q    <= '0;
      prod_q  <= '0;
      flags_q <= '0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      s1_q    <= s1_d;
      prod_q  <= prod_d;
      flags_q <= flags_d;
    end
  end

endmodule

// File: rtl/mac_dot_acc.sv
// Framed dot-product MAC: result strobes 2 enabled edges after the last element is sampled.
// No backpressure; clken stalls everything. MAC_SAT_EN selects clamping instead of wrapping.
module mac_dot_acc
  import mac_pkg::*;
#(
  parameter int A_W     = 8,
  parameter int B_W     = 8,
  parameter int GUARD_W = 10,
  parameter int SIGNED  = 0,
  localparam int ACC_W  = acc_width(A_W, B_W, GUARD_W)
) (
  input  logic             clk,
  input  logic             aclr,
  input  logic             clken,
  input  logic             in_valid,
  input  logic             in_first,
  input  logic             in_last,
  input  logic [A_W-1:0]   dataa,
  input  logic [B_W-1:0]   datab,
  output logic [ACC_W-1:0] dataout,
  output logic             dout_valid,
  output logic             dout_ovf
);

  localparam int P_W = A_W + B_W;

  stage_flags_t     in_flags, s2_flags;
  logic [P_W-1:0]   prod;
  logic [ACC_W-1:0] ext;
  logic [ACC_W:0]   sum_full;
  logic [ACC_W-1:0] sum;
  logic             add_ovf;

  logic [ACC_W-1:0] acc_q, acc_d;
  logic             sticky_q, sticky_d;
  logic [ACC_W-1:0] dataout_q, dataout_d;
  logic             dout_ovf_q, dout_ovf_d;
  logic             dout_valid_q, dout_valid_d;

`ifdef MAC_SAT_EN
  localparam logic [MAX_ACC_W-1:0] SAT_MAX_W = sat_max(SIGNED != 0, ACC_W);
  localparam logic [MAX_ACC_W-1:0] SAT_MIN_W = sat_min(SIGNED != 0, ACC_W);
  localparam logic [ACC_W-1:0]     SAT_MAX   = SAT_MAX_W[ACC_W-1:0];
  localparam logic [ACC_W-1:0]     SAT_MIN   = SAT_MIN_W[ACC_W-1:0];
`endif

  assign in_flags = '{valid: in_valid, first: in_first, last: in_last};

  mac_mult_stage #(
    .A_W    (A_W),
    .B_W    (B_W),
    .SIGNED (SIGNED)
  ) u_mult (
    .clk      (clk),
    .aclr     (aclr),
    .clken    (clken),
    .in_flags (in_flags),
    .dataa    (dataa),
    .datab    (datab),
    .prod_q   (prod),
    .flags_q  (s2_flags)
  );

  always_comb begin
    ext      = (SIGNED != 0) ? ACC_W'($signed(prod)) : ACC_W'(prod);
    sum_full = {1'b0, acc_q} + {1'b0, ext};
    sum      = sum_full[ACC_W-1:0];
    if (SIGNED != 0)
      add_ovf = (acc_q[ACC_W-1] == ext[ACC_W-1]) && (sum[ACC_W-1] != acc_q[ACC_W-1]);
    else
      add_ovf = sum_full[ACC_W];
  end

  always_comb begin
    acc_d        = acc_q;
    sticky_d     = sticky_q;
    dataout_d    = dataout_q;
    dout_ovf_d   = dout_ovf_q;
    dout_valid_d = dout_valid_q;
    if (clken) begin
      dout_valid_d = 1'b0;
      if (s2_flags.valid) begin
        if (s2_flags.first) begin
          acc_d    = ext;
          sticky_d = 1'b0;
        end else begin
          sticky_d = sticky_q | add_ovf;
`ifdef MAC_SAT_EN
          // A clamped accumulator is frozen until the next first element.
          if (sticky_q)
            acc_d = acc_q;
          else if (add_ovf)
            acc_d = ((SIGNED != 0) && ext[ACC_W-1]) ? SAT_MIN : SAT_MAX;
          else
            acc_d = sum;
`else
          acc_d = sum;
`endif
        end
        if (s2_flags.last) begin
          dataout_d    = acc_d;
          dout_ovf_d   = sticky_d;
          dout_valid_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      acc_q        <= '0;
      sticky_q     <= 1'b0;
      dataout_q    <= '0;
      dout_ovf_q   <= 1'b0;
      dout_valid_q <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      sticky_q     <= sticky_d;
      dataout_q    <= dataout_d;
      dout_ovf_q   <= dout_ovf_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  // The strobe register only clears on an enabled edge, so gating it with
  // clken shows it for exactly one enabled cycle even across a stall.
  assign dataout    = dataout_q;
  assign dout_ovf   = dout_ovf_q;
  assign dout_valid = dout_valid_q & clken;

endmodule

// File: tb/tb_mac_dot_acc.sv
// Directed bench for mac_dot_acc: unsigned, signed and zero-guard instances
// share one stimulus stream; each scenario checks the instance it targets.
module tb_mac_dot_acc;

  logic clk, aclr, clken, in_valid, in_first, in_last;
  logic [7:0] dataa, datab;

  logic [25:0] dout_u, dout_s;
  logic [15:0] dout_g;
  logic dv_u, dv_s, dv_g, ovf_u, ovf_s, ovf_g;

  int n_vec = 0;
  int n_err = 0;

  mac_dot_acc #(.A_W(8), .B_W(8), .GUARD_W(10), .SIGNED(0)) u_dut_u (
    .clk(clk), .aclr(aclr), .clken(clken), .in_valid(in_valid), .in_first(in_first),
    .in_last(in_last), .dataa(dataa), .datab(datab),
    .dataout(dout_u), .dout_valid(dv_u), .dout_ovf(ovf_u));

  mac_dot_acc #(.A_W(8), .B_W(8), .GUARD_W(10), .SIGNED(1)) u_dut_s (
    .clk(clk), .aclr(aclr), .clken(clken), .in_valid(in_valid), .in_first(in_first),
    .in_last(in_last), .dataa(dataa), .datab(datab),
    .dataout(dout_s), .dout_valid(dv_s), .dout_ovf(ovf_s));

  mac_dot_acc #(.A_W(8), .B_W(8), .GUARD_W(0), .SIGNED(0)) u_dut_g (
    .clk(clk), .aclr(aclr), .clken(clken), .in_valid(in_valid), .in_first(in_first),
    .in_last(in_last), .dataa(dataa), .datab(datab),
    .dataout(dout_g), .dout_valid(dv_g), .dout_ovf(ovf_g));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one beat, let the next rising edge sample it, settle 1ns after.
  task automatic beat(input logic v, input logic f, input logic l,
                      input logic [7:0] a, input logic [7:0] b);
    in_valid = v; in_first = f; in_last = l; dataa = a; datab = b;
    @(posedge clk);
    #1;
  endtask

  task automatic bubble();
    beat(1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    n_vec++; if (dv_u !== 1'b0 || dv_s !== 1'b0 || dv_g !== 1'b0) begin
      n_err++; $display("FAIL reset_valid: got u=%b s=%b g=%b want 0", dv_u, dv_s, dv_g); end
    n_vec++; if (dout_u !== 26'd0 || dout_s !== 26'd0 || dout_g !== 16'd0) begin
      n_err++; $display("FAIL reset_data: got u=%h s=%h g=%h want 0", dout_u, dout_s, dout_g); end
    n_vec++; if (ovf_u !== 1'b0 || ovf_s !== 1'b0 || ovf_g !== 1'b0) begin
      n_err++; $display("FAIL reset_ovf: got u=%b s=%b g=%b want 0", ovf_u, ovf_s, ovf_g); end
    aclr = 1'b0;
    bubble(); bubble();
  endtask

  task automatic test_unsigned();
    beat(1, 1, 0, 8'd3, 8'd4);
    beat(1, 0, 0, 8'd5, 8'd6);
    beat(1, 0, 1, 8'd7, 8'd8);
    bubble();
    n_vec++; if (dv_u !== 1'b0) begin
      n_err++; $display("FAIL uns_early_strobe: got %b want 0", dv_u); end
    bubble();
    n_vec++; if (dv_u !== 1'b1) begin
      n_err++; $display("FAIL uns_strobe: got %b want 1", dv_u); end
    n_vec++; if (dout_u !== 26'd98) begin
      n_err++; $display("FAIL uns_data: got %0d want 98", dout_u); end
    n_vec++; if (ovf_u !== 1'b0) begin
      n_err++; $display("FAIL uns_ovf: got %b want 0", ovf_u); end
    bubble();
    n_vec++; if (dv_u !== 1'b0 || dout_u !== 26'd98) begin
      n_err++; $display("FAIL uns_hold: got valid=%b data=%0d want 0/98", dv_u, dout_u); end
  endtask

  task automatic test_signed();
    beat(1, 1, 0, 8'hFD, 8'd4);     // -3 * 4
    beat(1, 0, 1, 8'd2, 8'hFB);     //  2 * -5
    beat(1, 1, 1, 8'h80, 8'h80);    // -128 * -128, alone
    n_vec++; if (dv_s !== 1'b0) begin
      n_err++; $display("FAIL sgn_early_strobe: got %b want 0", dv_s); end
    bubble();
    n_vec++; if (dv_s !== 1'b1 || dout_s !== 26'h3FFFFEA || ovf_s !== 1'b0) begin
      n_err++; $display("FAIL sgn_neg22: got v=%b d=%h o=%b want 1/3ffffea/0", dv_s, dout_s, ovf_s); end
    bubble();
    n_vec++; if (dv_s !== 1'b1 || dout_s !== 26'h0004000 || ovf_s !== 1'b0) begin
      n_err++; $display("FAIL sgn_16384: got v=%b d=%h o=%b want 1/0004000/0", dv_s, dout_s, ovf_s); end
    bubble();
    n_vec++; if (dv_s !== 1'b0) begin
      n_err++; $display("FAIL sgn_strobe_len: got %b want 0", dv_s); end
  endtask

  task automatic test_overflow();
    logic [15:0] exp_g;
`ifdef MAC_SAT_EN
    exp_g = 16'hFFFF;
`else
    exp_g = 16'hFC02;
`endif
    beat(1, 1, 0, 8'd255, 8'd255);
    beat(1, 0, 1, 8'd255, 8'd255);
    bubble(); bubble();
    n_vec++; if (dv_g !== 1'b1) begin
      n_err++; $display("FAIL ovf_strobe: got %b want 1", dv_g); end
    n_vec++; if (dout_g !== exp_g) begin
      n_err++; $display("FAIL ovf_data: got %h want %h", dout_g, exp_g); end
    n_vec++; if (ovf_g !== 1'b1) begin
      n_err++; $display("FAIL ovf_flag: got %b want 1", ovf_g); end
    // A fresh vector clears the sticky flag.
    beat(1, 1, 1, 8'd1, 8'd1);
    bubble(); bubble();
    n_vec++; if (dv_g !== 1'b1 || dout_g !== 16'd1 || ovf_g !== 1'b0) begin
      n_err++; $display("FAIL ovf_clear: got v=%b d=%h o=%b want 1/0001/0", dv_g, dout_g, ovf_g); end
  endtask

  task automatic test_clken();
    int strobes;
    strobes = 0;
    beat(1, 1, 0, 8'd2, 8'd2);
    clken = 1'b0;
    for (int i = 0; i < 5; i++) begin
      beat(1, 1, 1, 8'd7, 8'd7);    // must be ignored while stalled
      if (dv_u !== 1'b0) strobes++;
    end
    n_vec++; if (strobes != 0) begin
      n_err++; $display("FAIL clken_stall_strobe: got %0d strobes want 0", strobes); end
    clken = 1'b1;
    bubble(); bubble();
    n_vec++; if (dv_u !== 1'b0) begin
      n_err++; $display("FAIL clken_bubble_strobe: got %b want 0", dv_u); end
    beat(1, 0, 1, 8'd2, 8'd2);
    bubble();
    n_vec++; if (dv_u !== 1'b0) begin
      n_err++; $display("FAIL clken_early: got %b want 0", dv_u); end
    bubble();
    n_vec++; if (dv_u !== 1'b1 || dout_u !== 26'd8) begin
      n_err++; $display("FAIL clken_result: got v=%b d=%0d want 1/8", dv_u, dout_u); end
    bubble();
    n_vec++; if (dv_u !== 1'b0) begin
      n_err++; $display("FAIL clken_strobe_len: got %b want 0", dv_u); end
  endtask

  task automatic test_aclr();
    int strobes;
    strobes = 0;
    beat(1, 1, 0, 8'd3, 8'd3);
    beat(1, 0, 0, 8'd3, 8'd3);
    aclr = 1'b1;
    #1;
    n_vec++; if (dout_u !== 26'd0 || dv_u !== 1'b0 || ovf_u !== 1'b0 || dout_g !== 16'd0) begin
      n_err++; $display("FAIL aclr_outputs: got d=%0d v=%b o=%b g=%h want 0", dout_u, dv_u, ovf_u, dout_g); end
    @(posedge clk); #1;
    aclr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bubble();
      if (dv_u !== 1'b0) strobes++;
    end
    n_vec++; if (strobes != 0) begin
      n_err++; $display("FAIL aclr_no_strobe: got %0d strobes want 0", strobes); end
    beat(1, 1, 1, 8'd1, 8'd1);
    bubble(); bubble();
    n_vec++; if (dv_u !== 1'b1 || dout_u !== 26'd1) begin
      n_err++; $display("FAIL aclr_next: got v=%b d=%0d want 1/1", dv_u, dout_u); end
  endtask

  task automatic test_restart();
    beat(1, 1, 0, 8'd9, 8'd9);
    beat(1, 1, 1, 8'd1, 8'd1);
    bubble(); bubble();
    n_vec++; if (dv_u !== 1'b1 || dout_u !== 26'd1) begin
      n_err++; $display("FAIL restart: got v=%b d=%0d want 1/1", dv_u, dout_u); end
    // Elements after last without first keep accumulating from the held sum.
    beat(1, 0, 1, 8'd2, 8'd5);
    bubble(); bubble();
    n_vec++; if (dv_u !== 1'b1 || dout_u !== 26'd11) begin
      n_err++; $display("FAIL continue: got v=%b d=%0d want 1/11", dv_u, dout_u); end
  endtask

  task automatic test_back_to_back();
    beat(1, 1, 1, 8'd1, 8'd2);
    beat(1, 1, 1, 8'd3, 8'd4);
    beat(1, 1, 1, 8'd5, 8'd6);
    n_vec++; if (dv_u !== 1'b1 || dout_u !== 26'd2) begin
      n_err++; $display("FAIL b2b_0: got v=%b d=%0d want 1/2", dv_u, dout_u); end
    bubble();
    n_vec++; if (dv_u !== 1'b1 || dout_u !== 26'd12) begin
      n_err++; $display("FAIL b2b_1: got v=%b d=%0d want 1/12", dv_u, dout_u); end
    bubble();
    n_vec++; if (dv_u !== 1'b1 || dout_u !== 26'd30) begin
      n_err++; $display("FAIL b2b_2: got v=%b d=%0d want 1/30", dv_u, dout_u); end
    bubble();
    n_vec++; if (dv_u !== 1'b0 || dout_u !== 26'd30) begin
      n_err++; $display("FAIL b2b_end: got v=%b d=%0d want 0/30", dv_u, dout_u); end
  endtask

  initial begin
    aclr = 1'b1; clken = 1'b1;
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0; dataa = '0; datab = '0;
    test_reset();
    test_unsigned();
    test_signed();
    test_overflow();
    test_clken();
    test_aclr();
    test_restart();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
